// File: rtl/gcd_job_scheduler.sv
// rtl/gcd_job_scheduler.sv - job FIFO, launcher and result collector for gcd_processor
//
// Purpose: buffers operand pairs from an input valid/ready stream, issues them
// one at a time to a gcd_processor (start/num_0/num_1), captures gcd_op on done
// and presents each result with its operands on an output valid/ready stream,
// in arrival order. At most one job is in flight.
//
// Optional feature macro: GCD_SCHED_ZERO_BYPASS_EN
//   When defined, a head job with either operand equal to 0 is completed
//   locally (out_gcd = num_0 | num_1) without starting the processor.
//
// Ports:
//   clk_i, reset_n              clock, synchronous active-low reset
//   in_valid/in_ready           input job handshake, operands in_num_0/in_num_1
//   out_valid/out_ready         result handshake, out_gcd with out_num_0/out_num_1
//   gcd_start, gcd_num_0/1      launch pulse and operands to the processor
//   gcd_busy, gcd_done, gcd_op  processor status and result
//   pending                     FIFO occupancy, 0..FIFO_DEPTH

module gcd_job_scheduler #(
  parameter int BIT_LEN    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BIT_LEN-1:0]                 in_num_0,
  input  logic [BIT_LEN-1:0]                 in_num_1,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [BIT_LEN-1:0]                 out_gcd,
  output logic [BIT_LEN-1:0]                 out_num_0,
  output logic [BIT_LEN-1:0]                 out_num_1,
  output logic                               gcd_start,
  output logic [BIT_LEN-1:0]                 gcd_num_0,
  output logic [BIT_LEN-1:0]                 gcd_num_1,
  input  logic                               gcd_busy,
  input  logic                               gcd_done,
  input  logic [BIT_LEN-1:0]                 gcd_op,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t state;

  logic [BIT_LEN-1:0] fifo_num_0 [FIFO_DEPTH];
  logic [BIT_LEN-1:0] fifo_num_1 [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               ready_q;

  logic [BIT_LEN-1:0] op_num_0;
  logic [BIT_LEN-1:0] op_num_1;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               head_zero;
  logic [BIT_LEN-1:0] head_num_0;
  logic [BIT_LEN-1:0] head_num_1;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // ready_q keeps in_ready low until the first edge that samples reset_n high.
  assign in_ready   = ~full & ready_q & reset_n;
  assign push       = in_valid & in_ready;
  assign head_num_0 = fifo_num_0[rd_ptr];
  assign head_num_1 = fifo_num_1[rd_ptr];

`ifdef GCD_SCHED_ZERO_BYPASS_EN
  assign head_zero = (head_num_0 == '0) | (head_num_1 == '0);
`else
  assign head_zero = 1'b0;
`endif

  // Bypassed jobs never touch the processor, so busy only gates real launches.
  assign pop = (state == IDLE) & ~empty & (head_zero | ~gcd_busy);

  // FIFO storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_num_0[wr_ptr] <= in_num_0;
      fifo_num_1[wr_ptr] <= in_num_1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state     <= IDLE;
      gcd_start <= 1'b0;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      op_num_0  <= '0;
      op_num_1  <= '0;
    end else begin
      gcd_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            op_num_0 <= head_num_0;
            op_num_1 <= head_num_1;
            if (head_zero) begin
              // gcd(0, x) = x and gcd(0, 0) = 0 both reduce to an OR.
              out_gcd   <= head_num_0 | head_num_1;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              gcd_start <= 1'b1;
              state     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        WAIT: begin
          if (gcd_done) begin
            out_gcd   <= gcd_op;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gcd_num_0 = op_num_0;
  assign gcd_num_1 = op_num_1;
  assign out_num_0 = op_num_0;
  assign out_num_1 = op_num_1;
  assign pending   = count;

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// tb/tb_gcd_job_scheduler.sv - scoreboard bench for gcd_job_scheduler

module tb_gcd_job_scheduler;

  localparam int BL = 32;

  logic          clk_i = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [BL-1:0] in_num_0, in_num_1;
  logic          out_valid;
  logic          out_ready;
  logic [BL-1:0] out_gcd, out_num_0, out_num_1;
  logic          gcd_start;
  logic [BL-1:0] gcd_num_0, gcd_num_1;
  logic          gcd_busy;
  wire           gcd_done;
  wire  [BL-1:0] gcd_op;
  logic [2:0]    pending;

  logic          model_done;
  logic [BL-1:0] model_op;
  logic          spur_done;
  logic [BL-1:0] spur_op;
  int            lat;

  assign gcd_done = model_done | spur_done;
  assign gcd_op   = spur_done ? spur_op : model_op;

  always #5 clk_i = ~clk_i;

  gcd_job_scheduler #(.BIT_LEN(BL), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num_0(in_num_0), .in_num_1(in_num_1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gcd(out_gcd), .out_num_0(out_num_0), .out_num_1(out_num_1),
    .gcd_start(gcd_start), .gcd_num_0(gcd_num_0), .gcd_num_1(gcd_num_1),
    .gcd_busy(gcd_busy), .gcd_done(gcd_done), .gcd_op(gcd_op),
    .pending(pending)
  );

  typedef struct {
    logic [BL-1:0] g;
    logic [BL-1:0] a;
    logic [BL-1:0] b;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  function automatic logic [BL-1:0] euclid(input logic [BL-1:0] x, input logic [BL-1:0] y);
    logic [BL-1:0] a, b, t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Processor model: changes only on negedges, shares reset_n.
  initial begin
    int            cnt;
    logic [BL-1:0] res;
    cnt = 0;
    res = '0;
    model_done = 1'b0;
    model_op   = '0;
    gcd_busy   = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_n) begin
        gcd_busy   = 1'b0;
        model_done = 1'b0;
        cnt        = 0;
      end else if (model_done) begin
        model_done = 1'b0;
        gcd_busy   = 1'b0;
      end else if (gcd_busy) begin
        if (cnt <= 1) begin
          model_done = 1'b1;
          model_op   = res;
        end else begin
          cnt = cnt - 1;
        end
      end else if (gcd_start) begin
        gcd_busy = 1'b1;
        cnt      = lat;
        res      = euclid(gcd_num_0, gcd_num_1);
      end
    end
  end

  // Monitor: every output handshake is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (reset_n && out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_result: got gcd=%0d num=(%0d,%0d), required no result",
                   out_gcd, out_num_0, out_num_1);
        end else begin
          e = sb.pop_front();
          if (out_gcd !== e.g || out_num_0 !== e.a || out_num_1 !== e.b) begin
            miscompares++;
            $display("FAIL result: got gcd=%0d num=(%0d,%0d), required gcd=%0d num=(%0d,%0d)",
                     out_gcd, out_num_0, out_num_1, e.g, e.a, e.b);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [BL-1:0] g, input logic [BL-1:0] a, input logic [BL-1:0] b);
    exp_t e;
    e.g = g;
    e.a = a;
    e.b = b;
    sb.push_back(e);
  endtask

  task automatic push_job(input logic [BL-1:0] a, input logic [BL-1:0] b);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_num_0 = a;
    in_num_1 = b;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    check("push_accept", ok, 1);
  endtask

  task automatic wait_out_valid(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, ok, 1);
  endtask

  task automatic drain(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, ok, 1);
  endtask

  initial begin
    int   starts;
    logic bad;

    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_num_0  = 5;
    in_num_1  = 10;
    out_ready = 1'b0;
    spur_done = 1'b0;
    spur_op   = '0;
    lat       = 5;

    // Reset: held three cycles with in_valid asserted.
    tick(3);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_gcd_start", gcd_start, 0);
    check("rst_pending", pending, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_gcd_num_0", gcd_num_0, 0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    check("rst_in_ready_before_sample", in_ready, 0);
    tick();
    check("rst_in_ready_after_sample", in_ready, 1);
    check("rst_no_push", pending, 0);

    // Single job with a 40-cycle processor.
    lat       = 40;
    out_ready = 1'b1;
    expect_result(1, 2, 20261);
    push_job(2, 20261);
    check("single_pre_launch", gcd_start, 0);
    tick();
    check("single_launch_lat", gcd_start, 1);
    starts = 1;
    bad    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (gcd_start) starts++;
      if (out_valid) begin
        check("single_result_lat", gcd_done, 1);
        break;
      end
      if (gcd_num_0 !== 2 || gcd_num_1 !== 20261) bad = 1'b1;
    end
    check("single_start_pulses", starts, 1);
    check("single_num_stable", bad, 0);
    drain("single_drain");

    // Ordering and full: 5 accepted while out_ready is low.
    lat       = 3;
    out_ready = 1'b0;
    expect_result(6, 12, 18);
    push_job(12, 18);
    expect_result(7, 35, 14);
    push_job(35, 14);
    expect_result(4, 8, 12);
    push_job(8, 12);
    expect_result(9, 9, 27);
    push_job(9, 27);
    expect_result(5, 10, 25);
    push_job(10, 25);
    in_valid = 1'b1;
    in_num_0 = 7;
    in_num_1 = 5;
    tick(15);
    check("full_pending", pending, 4);
    check("full_in_ready", in_ready, 0);
    check("full_inflight_valid", out_valid, 1);
    check("full_inflight_gcd", out_gcd, 6);
    out_ready = 1'b1;
    expect_result(1, 7, 5);
    push_job(7, 5);
    drain("order_drain");
    check("order_pending_empty", pending, 0);

    // Backpressure with a spurious done pulse during HOLD.
    lat       = 4;
    out_ready = 1'b0;
    expect_result(14, 28, 42);
    push_job(28, 42);
    wait_out_valid("bp_valid_seen");
    expect_result(3, 9, 6);
    push_job(9, 6);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        spur_done = 1'b1;
        spur_op   = 999;
      end else begin
        spur_done = 1'b0;
      end
      tick();
      check("bp_out_gcd", out_gcd, 14);
      if (!out_valid || out_num_0 !== 28 || out_num_1 !== 42 || gcd_start) bad = 1'b1;
    end
    spur_done = 1'b0;
    check("bp_hold_stable", bad, 0);
    check("bp_queued", pending, 1);
    out_ready = 1'b1;
    drain("bp_drain");

    // Zero operand.
    lat = 4;
    expect_result(45, 0, 45);
    push_job(0, 45);
    tick();
`ifdef GCD_SCHED_ZERO_BYPASS_EN
    check("zero_bypass_valid", out_valid, 1);
    check("zero_bypass_gcd", out_gcd, 45);
    check("zero_bypass_no_start", gcd_start, 0);
`else
    check("zero_launch", gcd_start, 1);
`endif
    drain("zero_drain");

    // Mid-job reset during WAIT.
    lat       = 20;
    out_ready = 1'b1;
    push_job(15, 25);
    push_job(6, 4);
    tick(5);
    check("mid_pre_pending", pending, 1);
    reset_n = 1'b0;
    tick();
    check("mid_out_valid", out_valid, 0);
    check("mid_gcd_start", gcd_start, 0);
    check("mid_pending", pending, 0);
    check("mid_in_ready", in_ready, 0);
    check("mid_out_gcd", out_gcd, 0);
    check("mid_gcd_num_1", gcd_num_1, 0);
    check("mid_out_num_0", out_num_0, 0);
    reset_n = 1'b1;
    tick(3);
    spur_done = 1'b1;
    spur_op   = 77;
    tick();
    spur_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || gcd_start) bad = 1'b1;
    end
    check("mid_late_done_ignored", bad, 0);
    check("mid_post_pending", pending, 0);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
